// File: rtl/inst_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Optional bus timeout trap enabled with `define BUS_TIMEOUT_EN.
module inst_seq_ctrl #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             inst_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  input  logic             trap_clr,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_OPI   = 7'h13;
  localparam logic [6:0] OP_OP    = 7'h33;
  localparam logic [6:0] OP_FENCE = 7'h0f;
  localparam logic [6:0] OP_SYS   = 7'h73;

  localparam logic [1:0] C_NONE    = 2'd0;
  localparam logic [1:0] C_ILLEGAL = 2'd1;
  localparam logic [1:0] C_SYSTEM  = 2'd2;
  localparam logic [1:0] C_TIMEOUT = 2'd3;

  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic rf_we;
    logic pc_we;
  } strb_t;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD,
      OP_ST, OP_OPI, OP_OP, OP_FENCE, OP_SYS: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rf(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_OPI, OP_OP: writes_rf = 1'b1;
      default:                                                writes_rf = 1'b0;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [1:0]       cause_q, cause_d;
  logic             trap_q;
  logic [CNT_W-1:0] instret_q;
  logic             wait_hit;
  strb_t            strb;

`ifdef BUS_TIMEOUT_EN
  localparam int WAIT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_W   = (WAIT_RAW < 8) ? 8 : ((WAIT_RAW > 32) ? 32 : WAIT_RAW);
  logic [WAIT_W-1:0] wait_cnt;

  // wait_cnt = unacked cycles already spent; the TIMEOUT_CYCLES-th unacked cycle traps.
  assign wait_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if ((state_q == S_FETCH && !imem_ack) || (state_q == S_MEM && !dmem_ack))
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end
`else
  assign wait_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:
        if (run) state_d = S_FETCH;
      S_FETCH:
        if (imem_ack) state_d = S_DECODE;
        else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = C_TIMEOUT;
        end
      S_DECODE: begin
        op_d = opcode;
        if (is_legal(opcode)) state_d = S_EXEC;
        else begin
          state_d = S_TRAP;
          cause_d = C_ILLEGAL;
        end
      end
      S_EXEC:
        if (op_q == OP_LD || op_q == OP_ST) state_d = S_MEM;
        else if (op_q == OP_SYS) begin
          state_d = S_TRAP;
          cause_d = C_SYSTEM;
        end
        else state_d = S_WB;
      S_MEM:
        if (dmem_ack) state_d = S_WB;
        else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = C_TIMEOUT;
        end
      S_WB:
        state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:
        if (trap_clr) begin
          state_d = S_IDLE;
          cause_d = C_NONE;
        end
      default: begin
        state_d = S_IDLE;
        cause_d = C_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cause_q   <= C_NONE;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
      trap_q  <= (state_d == S_TRAP);
      if (state_q == S_WB) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    strb          = '0;
    strb.imem_req = (state_q == S_FETCH);
    strb.dmem_req = (state_q == S_MEM);
    strb.dmem_we  = (state_q == S_MEM) && (op_q == OP_ST);
    strb.rf_we    = (state_q == S_WB) && writes_rf(op_q);
    strb.pc_we    = (state_q == S_WB);
  end

  assign imem_req   = strb.imem_req;
  assign inst_we    = (state_q == S_FETCH) && imem_ack;
  assign dmem_req   = strb.dmem_req;
  assign dmem_we    = strb.dmem_we;
  assign rf_we      = strb.rf_we;
  assign pc_we      = strb.pc_we;
  assign busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed timing checks plus a randomized run scored against a per-instruction outcome model.
module tb_inst_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, dmem_ack, trap_clr;
  logic [6:0]  opcode;
  logic        imem_req, inst_we, dmem_req, dmem_we, rf_we, pc_we, busy, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [2:0]  state;

  inst_seq_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .imem_req(imem_req), .imem_ack(imem_ack), .inst_we(inst_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .trap_clr(trap_clr), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  // Expected architectural outcome of one decoded instruction
  typedef struct {
    bit       is_trap;
    bit       rf;
    bit       mem;
    bit       we;
    bit [1:0] cause;
  } exp_t;

  exp_t q[$];
  bit   sb_on = 0;
  int   exp_cnt = 0;
  bit   mem_seen = 0;
  bit   trap_prev = 0;
  bit [1:0] cur_cause = 0;

  logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  logic [6:0] rf_ops    [7]  = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33};

  function automatic bit in_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
    return 0;
  endfunction

  function automatic bit in_rf(input logic [6:0] op);
    foreach (rf_ops[i]) if (rf_ops[i] == op) return 1;
    return 0;
  endfunction

  function automatic exp_t model(input logic [6:0] op);
    exp_t e;
    e.is_trap = 0; e.rf = 0; e.mem = 0; e.we = 0; e.cause = 0;
    if (!in_legal(op)) begin e.is_trap = 1; e.cause = 2'd1; end
    else if (op == 7'h73) begin e.is_trap = 1; e.cause = 2'd2; end
    else begin
      e.rf  = in_rf(op);
      e.mem = (op == 7'h03) || (op == 7'h23);
      e.we  = (op == 7'h23);
    end
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (sb_on) begin
      exp_t it;
      if (state == 3'd0) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_strobes", 32'({imem_req, dmem_req, rf_we, pc_we}), 32'd0);
      end
      if (dmem_req) begin
        if (q.size() == 0 || !q[0].mem) begin
          total++; bad++;
          $display("FAIL unexp_dmem: got dmem_req=1 want 0 (queued=%0d)", q.size());
        end else begin
          chk("dmem_we", 32'(dmem_we), 32'(q[0].we));
          if (dmem_ack) mem_seen = 1;
        end
      end
      if (pc_we) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexp_retire: got pc_we=1 want no retire");
        end else begin
          it = q.pop_front();
          chk("retire_kind", 32'(it.is_trap), 32'd0);
          chk("retire_rf_we", 32'(rf_we), 32'(it.rf));
          chk("retire_mem", 32'(mem_seen), 32'(it.mem));
          chk("retire_instret", instret, 32'(exp_cnt));
          exp_cnt++;
        end
        mem_seen = 0;
      end
      if (trap && !trap_prev) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexp_trap: got trap=1 want 0");
        end else begin
          it = q.pop_front();
          chk("trap_kind", 32'(it.is_trap), 32'd1);
          cur_cause = it.cause;
        end
        mem_seen = 0;
      end
      if (trap) begin
        chk("trap_cause", 32'(trap_cause), 32'(cur_cause));
        chk("trap_instret", instret, 32'(exp_cnt));
        chk("trap_busy", 32'(busy), 32'd0);
        chk("trap_strobes", 32'({imem_req, dmem_req, rf_we, pc_we}), 32'd0);
      end else begin
        chk("cause_clear", 32'(trap_cause), 32'd0);
      end
      trap_prev = trap;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] seq [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    int n;
    bit drain;
    exp_t e;
    int r;

    rst_n = 0; run = 0; opcode = 7'h13; imem_ack = 0; dmem_ack = 0; trap_clr = 0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_outs", 32'({imem_req, inst_we, dmem_req, dmem_we, rf_we, pc_we, busy, trap, trap_cause}), 32'd0);

    // Back-to-back ALU ops with same-cycle acks
    @(negedge clk);
    rst_n = 1; run = 1; imem_ack = 1; dmem_ack = 1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("seq_state", 32'(state), 32'(seq[i % 4]));
      chk("seq_pc_we", 32'(pc_we), 32'(i % 4 == 3));
      chk("seq_rf_we", 32'(rf_we), 32'(i % 4 == 3));
      chk("seq_inst_we", 32'(inst_we), 32'(i % 4 == 0));
      chk("seq_instret", instret, 32'(i / 4));
    end

    // Async reset while a fetch is outstanding
    imem_ack = 0;
    n = 0;
    while (state != 3'd1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("pre_rst_imem_req", 32'(imem_req), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_outs", 32'({imem_req, inst_we, rf_we, pc_we, busy, trap}), 32'd0);
    chk("async_rst_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1; run = 1;
    @(posedge clk); #1;
    chk("resume_fetch", 32'(state), 32'd1);

    // Store whose data ack arrives in the fourth MEM cycle
    imem_ack = 1; opcode = 7'h23; dmem_ack = 0;
    n = 0;
    while (state != 3'd4 && n < 20) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 4; k++) begin
      chk("st_mem_state", 32'(state), 32'd4);
      chk("st_dmem", 32'({dmem_req, dmem_we}), 32'd3);
      if (k == 3) dmem_ack = 1;
      @(posedge clk); #1;
    end
    dmem_ack = 0;
    chk("st_wb_state", 32'(state), 32'd5);
    chk("st_wb_strobes", 32'({rf_we, pc_we}), 32'd1);

    // Randomized phase
    rst_n = 0; run = 0; imem_ack = 0; trap_clr = 0;
    #3;
    @(negedge clk);
    rst_n = 1;
    exp_cnt = 0; mem_seen = 0; trap_prev = 0; cur_cause = 0;
    q.delete();
    sb_on = 1;
    drain = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      drain = (c >= 4950);
      if (state == 3'd2) begin
        r = $urandom_range(0, 15);
        if (r < 11) opcode = legal_ops[r];
        else if (r == 11) opcode = 7'h7f;
        else opcode = 7'($urandom);
        e = model(opcode);
        q.push_back(e);
      end else begin
        opcode = 7'($urandom);
      end
      if (drain) begin
        run = 0; imem_ack = 1; dmem_ack = 1; trap_clr = 1;
      end else begin
        run      = ($urandom_range(0, 7) != 0);
        imem_ack = ($urandom_range(0, 1) == 0);
        dmem_ack = ($urandom_range(0, 2) == 0);
        trap_clr = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    sb_on = 0;
    chk("drain_state", 32'(state), 32'd0);
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("retired_enough", 32'(exp_cnt > 50), 32'd1);
    chk("final_instret", instret, 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_seq_ctrl.md
Name: inst_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, then WB.
- Handshakes with instruction and data memory, and produces the enable strobes for the fetch latch, register file and PC.
- Sits beside the fetch, decode and execute stages; reads the opcode that the decode stage extracts, and traps on illegal or system opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.
- TIMEOUT_CYCLES, 255, maximum cycles a memory request waits for its ack (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = execute instructions
- opcode  in  7  inst[6:0] from the decode stage; valid from DECODE onward
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction available this cycle
- inst_we  out  1  latch fetched instruction into the fetch register
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
- dmem_ack  in  1  data access complete this cycle
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- busy  out  1  1 in any state except IDLE and TRAP
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 none, 1 illegal opcode, 2 ecall/ebreak (0x73), 3 bus timeout
- trap_clr  in  1  clears trap
- instret  out  CNT_W  retired-instruction count
- state  out  3  encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6

Behaviour:
- Reset: asserting rst_n=0 forces state=IDLE, op_q=0, instret=0, trap=0, trap_cause=0, and all strobes and requests to 0 immediately, including mid-handshake.
- Outputs are decoded from the registered state and op_q, except inst_we, which equals (state==FETCH && imem_ack).
- IDLE: move to FETCH when run=1.
- FETCH:
  - imem_req=1, held until imem_ack.
  - On ack: inst_we=1 and move to DECODE.
- DECODE: one cycle; op_q <= opcode.
  - Legal set: 37,17,6f,67,63,03,23,13,33,0f,73 (hex). Legal opcode goes to EXEC.
  - Any other opcode goes to TRAP with cause 1.
- EXEC: one cycle, branching on op_q:
  - 03 or 23 goes to MEM.
  - 73 goes to TRAP with cause 2; pc_we is not asserted.
  - Everything else goes to WB.
- MEM:
  - dmem_req=1 and dmem_we=(op_q==23), held until dmem_ack.
  - On ack: move to WB.
- WB: one cycle.
  - pc_we=1.
  - rf_we=1 if op_q is one of 37,17,6f,67,03,13,33 (rf_we=0 for 63, 23, 0f).
  - instret+1, wrapping from 2^CNT_W-1 to 0.
  - Then go to FETCH if run=1, else IDLE.
- TRAP:
  - trap=1; all strobes 0; instret frozen.
  - trap_clr=1 moves to IDLE and clears trap and trap_cause in the same edge.
  - trap_clr in any other state is ignored.
- run=0 mid-instruction: the current instruction completes through WB; no new fetch starts.
- Ack handling: imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- An ack arriving in the first cycle of a request is legal.
- Latency with same-cycle acks: 4 cycles per instruction (FETCH, DECODE, EXEC, WB); 5 cycles for loads and stores.
- trap_cause holds its value until trap_clr or reset.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined:
  - An 8..32-bit wait counter clears on entry to FETCH or MEM and increments each cycle the request is unacked.
  - When it reaches TIMEOUT_CYCLES without an ack: drop the request, go to TRAP with cause 3.
  - An ack arriving in the same cycle the count reaches the limit wins; no trap is taken.
- When not defined: no counter; requests wait indefinitely; cause 3 never occurs.

Test Plan:
- Reset, run=1, opcode=13, imem_ack and dmem_ack tied to 1 → state sequence 1,2,3,5 repeating.
  - rf_we and pc_we pulse once per 4 cycles.
  - instret=3 after 12 cycles.
- opcode=23, dmem_ack delayed 3 cycles → MEM lasts 4 cycles with dmem_req=1 and dmem_we=1; then WB with rf_we=0, pc_we=1.
- opcode=7f → TRAP in the cycle after DECODE; trap=1, trap_cause=1, instret unchanged; trap_clr=1 → state=0, trap=0.
- opcode=73 → TRAP from EXEC, trap_cause=2, no pc_we pulse.
- Drop run to 0 during MEM of a load (opcode=03) → WB completes with rf_we=1, then IDLE, busy=0.
- rst_n=0 pulsed while imem_req=1 → all outputs 0 asynchronously; resumes at FETCH one cycle after release with run=1. With BUS_TIMEOUT_EN and imem_ack held at 0 → trap_cause=3 after 255 cycles.
